disp_src_sel: RTL and testbench

DISP_SRC_SEL -- requirements
Module: disp_src_sel

---
 rtl/disp_src_sel.sv | 130 +++++++++++++
 tb/tb_disp_src_sel.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/disp_src_sel.sv
// disp_src_sel: picks the display word from memory channels or debounced
// switches, in manual, rotate or hold mode, with a change pulse.
module disp_src_sel #(
    parameter  int DW      = 32,
    parameter  int SW_W    = 16,
    parameter  int NCH     = 4,
    parameter  int DEB_CYC = 4,
    parameter  int ROT_DIV = 8,
    localparam int CW      = $clog2(NCH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              switch_cs,
    input  logic [SW_W-1:0]   sw,
    input  logic [NCH*DW-1:0] data_in,
    input  logic [CW-1:0]     ch_sel,
    input  logic [1:0]        mode,
    output logic [DW-1:0]     data_sel,
    output logic [CW-1:0]     cur_src,
    output logic              upd
);

    localparam int DBW = $clog2(DEB_CYC + 1);
    localparam int DVW = $clog2(ROT_DIV);
    localparam logic [DBW-1:0] DEB_MAX = DBW'(DEB_CYC);
    localparam logic [DBW-1:0] DEB_M1 = DBW'(DEB_CYC - 1);
    localparam logic [DVW-1:0] DIV_LAST = DVW'(ROT_DIV - 1);

    if (SW_W > DW || NCH < 2 || NCH > 16 || DEB_CYC < 1 || ROT_DIV < 2)
    begin : g_bad_params
        $error("disp_src_sel: illegal parameter combination");
    end

    logic [SW_W-1:0] sync1, sync2, cand, sw_db, sw_db_nxt;
    logic [DBW-1:0]  cnt;
    logic [DVW-1:0]  div, div_base, div_nxt;
    logic            was_rot, is_rot, is_hold, wrap;
    logic [CW-1:0]   cur_adj, cur_rot, cur_nxt;
    logic [DW-1:0]   src_word;

    // The debounced value is forwarded so it reaches data_sel on the same
    // edge that sw_db itself loads it.
    always_comb begin
        sw_db_nxt = sw_db;
        if (sync2 == cand && cnt == DEB_M1) begin
            sw_db_nxt = cand;
        end
    end

    always_comb begin
        is_rot   = (mode == 2'b01);
        is_hold  = (mode == 2'b10);
        div_base = was_rot ? div : '0;
        wrap     = (div_base == DIV_LAST);
        cur_adj  = cur_src;
        if (int'(cur_src) > NCH) begin
            cur_adj = CW'(int'(cur_src) - (NCH + 1));
        end
        cur_rot = (int'(cur_adj) == NCH) ? '0 : cur_adj + 1'b1;
        cur_nxt = cur_src;
        div_nxt = div;
        unique case (1'b1)
            is_hold: begin
                cur_nxt = cur_src;
            end
            is_rot: begin
                div_nxt = wrap ? '0 : div_base + 1'b1;
                if (wrap) begin
                    cur_nxt = cur_rot;
                end
            end
            default: begin
                cur_nxt = switch_cs ? CW'(NCH) : ch_sel;
            end
        endcase
    end

    always_comb begin
        src_word = '0;
        if (int'(cur_nxt) == NCH) begin
            src_word[SW_W-1:0] = sw_db_nxt;
        end
        for (int k = 0; k < NCH; k++) begin
            if (int'(cur_nxt) == k) begin
                src_word = data_in[k*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            cand  <= '0;
            cnt   <= '0;
            sw_db <= '0;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= '0;
            end else if (cnt != DEB_MAX) begin
                cnt <= cnt + 1'b1;
            end
            sw_db <= sw_db_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_sel <= '0;
            cur_src  <= '0;
            upd      <= 1'b0;
            div      <= '0;
            was_rot  <= 1'b0;
        end else begin
            cur_src <= cur_nxt;
            div     <= div_nxt;
            was_rot <= is_rot;
            if (is_hold) begin
                upd <= 1'b0;
            end else begin
                data_sel <= src_word;
                upd      <= (src_word != data_sel);
            end
        end
    end

endmodule

// File: tb/tb_disp_src_sel.sv
// tb_disp_src_sel: table-driven vectors for manual/hold selection plus
// directed sequences for debounce, rotation and mid-run reset.
module tb_disp_src_sel;

    logic         clk;
    logic         rst_n;
    logic         switch_cs;
    logic [15:0]  sw;
    logic [127:0] data_in;
    logic [2:0]   ch_sel;
    logic [1:0]   mode;
    logic [31:0]  data_sel;
    logic [2:0]   cur_src;
    logic         upd;

    int n_chk;
    int n_fail;

    disp_src_sel dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .switch_cs (switch_cs),
        .sw        (sw),
        .data_in   (data_in),
        .ch_sel    (ch_sel),
        .mode      (mode),
        .data_sel  (data_sel),
        .cur_src   (cur_src),
        .upd       (upd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  mode;
        logic        cs;
        logic [2:0]  ch;
        logic        wr;
        int          wch;
        logic [31:0] wval;
        logic [31:0] e_data;
        logic [2:0]  e_src;
        logic        e_upd;
    } vec_t;

    vec_t vt[15];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rot_data(input int c);
        return (c < 4) ? 32'h100 + c : 32'h12;
    endfunction

    task automatic init_data();
        for (int k = 0; k < 4; k++) begin
            data_in[k*32 +: 32] = 32'h100 + k;
        end
    endtask

    task automatic rot_run(input string tag, input int n_edges);
        int c;
        for (int n = 1; n <= n_edges; n++) begin
            edge1();
            c = (n / 8) % 5;
            check($sformatf("%s src n=%0d", tag, n), 32'(cur_src), c);
            check($sformatf("%s data n=%0d", tag, n), data_sel, rot_data(c));
            check($sformatf("%s upd n=%0d", tag, n), 32'(upd),
                  32'((n % 8 == 0) || (n == 1)));
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;

        vt[0]  = '{2'b00, 1'b0, 3'd2, 1'b1, 2, 32'hDEADBEEF,
                   32'hDEADBEEF, 3'd2, 1'b1};
        vt[1]  = '{2'b00, 1'b0, 3'd2, 1'b0, 0, 32'h0,
                   32'hDEADBEEF, 3'd2, 1'b0};
        vt[2]  = '{2'b00, 1'b0, 3'd0, 1'b0, 0, 32'h0,
                   32'h100, 3'd0, 1'b1};
        vt[3]  = '{2'b00, 1'b1, 3'd0, 1'b0, 0, 32'h0,
                   32'h0, 3'd4, 1'b1};
        vt[4]  = '{2'b00, 1'b0, 3'd5, 1'b0, 0, 32'h0,
                   32'h0, 3'd5, 1'b0};
        vt[5]  = '{2'b00, 1'b0, 3'd7, 1'b0, 0, 32'h0,
                   32'h0, 3'd7, 1'b0};
        vt[6]  = '{2'b00, 1'b0, 3'd3, 1'b0, 0, 32'h0,
                   32'h103, 3'd3, 1'b1};
        vt[7]  = '{2'b10, 1'b0, 3'd3, 1'b1, 3, 32'h33333333,
                   32'h103, 3'd3, 1'b0};
        vt[8]  = '{2'b10, 1'b0, 3'd1, 1'b0, 0, 32'h0,
                   32'h103, 3'd3, 1'b0};
        vt[9]  = '{2'b11, 1'b0, 3'd3, 1'b0, 0, 32'h0,
                   32'h33333333, 3'd3, 1'b1};
        vt[10] = '{2'b11, 1'b0, 3'd1, 1'b0, 0, 32'h0,
                   32'h101, 3'd1, 1'b1};
        vt[11] = '{2'b00, 1'b0, 3'd1, 1'b1, 1, 32'h55,
                   32'h55, 3'd1, 1'b1};
        vt[12] = '{2'b10, 1'b0, 3'd1, 1'b1, 1, 32'h66,
                   32'h55, 3'd1, 1'b0};
        vt[13] = '{2'b00, 1'b0, 3'd1, 1'b0, 0, 32'h0,
                   32'h66, 3'd1, 1'b1};
        vt[14] = '{2'b00, 1'b0, 3'd1, 1'b0, 0, 32'h0,
                   32'h66, 3'd1, 1'b0};

        rst_n = 1'b0;
        switch_cs = 1'b0;
        sw = 16'h0;
        ch_sel = 3'd0;
        mode = 2'b00;
        init_data();
        #12;
        check("reset data_sel", data_sel, 32'h0);
        check("reset cur_src", 32'(cur_src), 32'h0);
        check("reset upd", 32'(upd), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            mode = vt[i].mode;
            switch_cs = vt[i].cs;
            ch_sel = vt[i].ch;
            if (vt[i].wr) begin
                data_in[vt[i].wch*32 +: 32] = vt[i].wval;
            end
            edge1();
            check($sformatf("vec%0d data_sel", i), data_sel, vt[i].e_data);
            check($sformatf("vec%0d cur_src", i), 32'(cur_src),
                  32'(vt[i].e_src));
            check($sformatf("vec%0d upd", i), 32'(upd), 32'(vt[i].e_upd));
        end

        // Clean switch step: visible exactly 7 edges after the change.
        switch_cs = 1'b1;
        edge1();
        check("sw start data", data_sel, 32'h0);
        sw = 16'hA5A5;
        for (int e = 1; e <= 8; e++) begin
            edge1();
            check($sformatf("deb data e=%0d", e), data_sel,
                  (e >= 7) ? 32'h0000A5A5 : 32'h0);
            if (e >= 6) begin
                check($sformatf("deb upd e=%0d", e), 32'(upd),
                      32'(e == 7));
            end
        end

        // Bouncing switches never get accepted.
        for (int i = 0; i < 10; i++) begin
            sw = (i % 2 == 0) ? 16'h5A5A : 16'hA5A5;
            for (int j = 0; j < 2; j++) begin
                edge1();
                check($sformatf("bounce data i=%0d", i), data_sel,
                      32'h0000A5A5);
            end
        end

        // Rotate from reset with switches reading 0x0012.
        init_data();
        sw = 16'h0012;
        mode = 2'b01;
        switch_cs = 1'b1;
        ch_sel = 3'd2;
        rst_n = 1'b0;
        #4;
        rst_n = 1'b1;
        rot_run("rot", 48);

        // Half-cycle reset pulse mid-rotation.
        #1;
        rst_n = 1'b0;
        #2;
        check("midrst data_sel", data_sel, 32'h0);
        check("midrst cur_src", 32'(cur_src), 32'h0);
        check("midrst upd", 32'(upd), 32'h0);
        #3;
        rst_n = 1'b1;
        rot_run("rerot", 20);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
